// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param: runtime-programmable Moore serial pattern detector, registered Q.
// Define SEQDET_HITCNT_EN to build the saturating hit counter; otherwise hit_cnt is tied to 0.
module seq_detector_moore_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b101),
  parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(3),
  parameter logic DEF_OVL = 1'b0
) (
  input  logic               clk,
  input  logic               _rst,
  input  logic               cfg_ld,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               ovl,
  input  logic               en,
  input  logic               D,
  output logic               Q,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   hit_cnt
);
  logic [MAX_LEN-1:0] pat_q, mask, hist_nx;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0] len_q, fill, fill_nx;
  logic ovl_q, hit_st, hit_nx;
  // Only the low len_q bits of history and pattern take part in the match
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = len_q > LEN_W'(i);
  end
  always_comb begin
    hist_nx = {hist, D};
    fill_nx = (!ovl_q && hit_st) ? LEN_W'(1) : (fill >= len_q ? len_q : fill + LEN_W'(1));
    hit_nx = !cfg_err && fill_nx == len_q && ((hist_nx ^ pat_q) & mask) == '0;
  end
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      pat_q <= DEF_PAT;
      len_q <= DEF_LEN;
      ovl_q <= DEF_OVL;
      cfg_err <= 1'b0;
      hist <= '0;
      fill <= '0;
      hit_st <= 1'b0;
      Q <= 1'b0;
    end else if (cfg_ld) begin
      pat_q <= pat;
      len_q <= pat_len;
      ovl_q <= ovl;
      cfg_err <= pat_len == '0 || pat_len > LEN_W'(MAX_LEN);
      hist <= '0;
      fill <= '0;
      hit_st <= 1'b0;
      Q <= 1'b0;
    end else begin
      Q <= hit_st;
      if (en) begin
        hist <= hist_nx[MAX_LEN-2:0];
        fill <= fill_nx;
        hit_st <= hit_nx;
      end
    end
  end
`ifdef SEQDET_HITCNT_EN
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) hit_cnt <= '0;
    else if (cfg_ld) hit_cnt <= '0;
    else if (en && hit_nx && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
  end
`else
  assign hit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_moore_param.sv
// tb_seq_detector_moore_param: table-driven checks of the Moore detector plus enable-gap and reset sequences.
module tb_seq_detector_moore_param;
  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       en;
    logic       d;
    logic       q;
    logic       err;
    int         cnt;
  } vec_t;
  logic clk = 0, rst_n = 0, cfg_ld = 0, ovl = 0, en = 0, D = 0;
  logic [7:0] pat = 0;
  logic [3:0] pat_len = 0;
  logic Q, cfg_err;
  logic [7:0] hit_cnt;
  int tests = 0, fails = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  seq_detector_moore_param dut (
    .clk(clk), ._rst(rst_n), .cfg_ld(cfg_ld), .pat(pat), .pat_len(pat_len), .ovl(ovl),
    .en(en), .D(D), .Q(Q), .cfg_err(cfg_err), .hit_cnt(hit_cnt)
  );
  function automatic vec_t ld(logic [7:0] p, logic [3:0] l, logic o, logic err);
    vec_t r;
    r = '{ld: 1'b1, pat: p, len: l, ovl: o, en: 1'b1, d: 1'b1, q: 1'b0, err: err, cnt: 0};
    return r;
  endfunction
  function automatic vec_t sm(logic e, logic d, logic q, logic err, int cnt);
    vec_t r;
    r = '{ld: 1'b0, pat: 8'h00, len: 4'd0, ovl: 1'b0, en: e, d: d, q: q, err: err, cnt: cnt};
    return r;
  endfunction
  function automatic int ec(int c);
`ifdef SEQDET_HITCNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction
  task automatic check(string nm, logic eq, logic eerr, int ecnt);
    tests++;
    if (Q !== eq || cfg_err !== eerr || hit_cnt !== 8'(ec(ecnt))) begin
      fails++;
      $display("FAIL %s: Q=%0b cfg_err=%0b hit_cnt=%0d, expected Q=%0b cfg_err=%0b hit_cnt=%0d",
               nm, Q, cfg_err, hit_cnt, eq, eerr, ec(ecnt));
    end
  endtask
  task automatic step(vec_t r, string nm);
    cfg_ld = r.ld; pat = r.pat; pat_len = r.len; ovl = r.ovl; en = r.en; D = r.d;
    @(posedge clk);
    #1;
    check(nm, r.q, r.err, r.cnt);
  endtask
  task automatic mid_reset(string nm);
    rst_n = 0;
    #2;
    check(nm, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    // defaults 101 non-overlap: single hit, trailing 101 rejected
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,0)); v.push_back(sm(1,1,0,0,1));
    v.push_back(sm(1,0,1,0,1)); v.push_back(sm(1,1,0,0,1)); v.push_back(sm(0,0,0,0,1));
    // overlap 101
    v.push_back(ld(8'h05,4'd3,1'b1,1'b0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,0)); v.push_back(sm(1,1,0,0,1));
    v.push_back(sm(1,0,1,0,1)); v.push_back(sm(1,1,0,0,2)); v.push_back(sm(0,0,1,0,2));
    v.push_back(sm(1,0,1,0,2)); v.push_back(sm(1,0,0,0,2));
    // 1111 overlap, run of six ones
    v.push_back(ld(8'h0F,4'd4,1'b1,1'b0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,1,0,0,0));
    v.push_back(sm(1,1,0,0,1)); v.push_back(sm(1,1,1,0,2)); v.push_back(sm(1,1,1,0,3));
    v.push_back(sm(1,0,1,0,3)); v.push_back(sm(1,0,0,0,3));
    // len=1, pattern 0
    v.push_back(ld(8'h00,4'd1,1'b0,1'b0));
    v.push_back(sm(1,0,0,0,1)); v.push_back(sm(1,0,1,0,2)); v.push_back(sm(1,1,1,0,2));
    v.push_back(sm(1,0,0,0,3)); v.push_back(sm(1,1,1,0,3)); v.push_back(sm(0,0,0,0,3));
    // bad lengths 0 and 9
    v.push_back(ld(8'h05,4'd0,1'b0,1'b1));
    v.push_back(sm(1,1,0,1,0)); v.push_back(sm(1,0,0,1,0)); v.push_back(sm(1,1,0,1,0));
    v.push_back(sm(1,0,0,1,0)); v.push_back(sm(1,1,0,1,0));
    v.push_back(ld(8'h05,4'd9,1'b0,1'b1));
    v.push_back(sm(1,1,0,1,0)); v.push_back(sm(1,0,0,1,0)); v.push_back(sm(1,1,0,1,0));
    // full length 8, pattern 10110010
    v.push_back(ld(8'hB2,4'd8,1'b0,1'b0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,0)); v.push_back(sm(1,1,0,0,0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,0)); v.push_back(sm(1,0,0,0,0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,1)); v.push_back(sm(0,0,1,0,1));
    v.push_back(sm(0,1,1,0,1)); v.push_back(sm(1,0,1,0,1)); v.push_back(sm(0,0,0,0,1));
    // pattern bits above len ignored
    v.push_back(ld(8'hF5,4'd3,1'b0,1'b0));
    v.push_back(sm(1,1,0,0,0)); v.push_back(sm(1,0,0,0,0)); v.push_back(sm(1,1,0,0,1));
    v.push_back(sm(0,0,1,0,1)); v.push_back(sm(1,1,1,0,1)); v.push_back(sm(0,0,0,0,1));
    #3;
    check("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    foreach (v[i]) step(v[i], $sformatf("vec%0d", i));
    // enable gaps are invisible to the matcher
    step(ld(8'h05,4'd3,1'b0,1'b0), "gap_ld");
    step(sm(1,1,0,0,0), "gap_d1");
    repeat (3) step(sm(0,0,0,0,0), "gap_hold");
    step(sm(1,0,0,0,0), "gap_d0");
    step(sm(1,1,0,0,1), "gap_d1b");
    step(sm(1,0,1,0,1), "gap_pulse");
    step(sm(1,0,0,0,1), "gap_end");
    // async reset clears Q/hit_cnt at once and restores the default config
    step(ld(8'h01,4'd1,1'b1,1'b0), "rst_ld");
    step(sm(1,1,0,0,1), "rst_h1");
    step(sm(1,1,1,0,2), "rst_h2");
    mid_reset("rst_async");
    step(sm(1,1,0,0,0), "rst_def1");
    step(sm(1,0,0,0,0), "rst_def0");
    mid_reset("rst_async2");
    step(sm(1,1,0,0,0), "rst_partial");
    step(sm(1,0,0,0,0), "rst_p0");
    step(sm(1,1,0,0,1), "rst_p1");
    step(sm(0,0,1,0,1), "rst_defhit");
    step(ld(8'h05,4'd0,1'b0,1'b1), "rst_errld");
    mid_reset("rst_err");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
